// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch-stage types and constants
package pipeline_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] HALT_INST_DEFAULT = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_pipe_reg.sv
// fetch_pipe_reg: fetch-to-B pipeline register with load, hold and bubble controls
module fetch_pipe_reg import pipeline_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);
  logic [31:0] inst_q, inst_d, pc_q, pc_d;
  logic valid_q, valid_d;
  always_comb begin
    inst_d = bubble ? NOP_INST : load ? inst_i : inst_q;
    pc_d = bubble ? 32'd0 : load ? pc_i : pc_q;
    valid_d = bubble ? 1'b0 : load ? 1'b1 : valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= NOP_INST;
      pc_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      inst_q <= inst_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
    end
  end
  assign inst_o = inst_q;
  assign pc_o = pc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, BOOT/RUN/HALT control and delivered-instruction counter
module fetch_stage import pipeline_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_INST = HALT_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] pc_out_B,
  output logic [31:0] IM_out_B,
  output logic        valid_B,
  output logic        halted,
  output logic [31:0] fetch_count
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, count_q, count_d;
  logic adv, redirect;
  always_comb begin
    redirect = state_q == RUN && br_taken_i;
    adv = state_q == RUN && !br_taken_i && !stall_i;
    pc_d = redirect ? {br_target_i[31:2], 2'b00} : adv ? pc_q + 32'd4 : pc_q;
    count_d = adv && count_q != '1 ? count_q + 32'd1 : count_q;
    state_d = state_q == BOOT ? RUN : adv && imem_rdata == HALT_INST ? HALT : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      count_q <= count_d;
    end
  end
  fetch_pipe_reg u_pipe (
    .clk(clk),
    .rst(rst),
    .load(adv),
    .bubble(state_q != RUN || redirect),
    .inst_i(imem_rdata),
    .pc_i(pc_q),
    .inst_o(IM_out_B),
    .pc_o(pc_out_B),
    .valid_o(valid_B)
  );
  assign imem_addr = pc_q;
  assign halted = state_q == HALT;
  assign fetch_count = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  localparam logic [31:0] HALT_W = 32'h0010_0073;
  localparam logic [31:0] NOP_W = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, stall, br;
  logic [31:0] tgt;
  logic [31:0] addr, rdata, pc_b, im_b, cnt;
  logic valid_b, hlt;
  logic [31:0] addr2, rdata2, pc_b2, im_b2, cnt2;
  logic valid_b2, hlt2;
  int n_chk = 0, n_err = 0;
  bit started = 0;
  logic [31:0] m_pc, m_inst, m_bpc, m_cnt;
  logic m_valid, m_boot, m_halt;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    if (w == HALT_W) w = NOP_W;
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00A0_0113 : a == 32'h10 ? HALT_W : w;
  endfunction

  assign rdata = mem(addr);
  assign rdata2 = mem(addr2);

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(addr), .imem_rdata(rdata),
    .stall_i(stall), .br_taken_i(br), .br_target_i(tgt),
    .pc_out_B(pc_b), .IM_out_B(im_b), .valid_B(valid_b),
    .halted(hlt), .fetch_count(cnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_addr(addr2), .imem_rdata(rdata2),
    .stall_i(stall), .br_taken_i(br), .br_target_i(tgt),
    .pc_out_B(pc_b2), .IM_out_B(im_b2), .valid_B(valid_b2),
    .halted(hlt2), .fetch_count(cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what one clock edge must do, straight from the behavioural rules
  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      m_boot = 1; m_halt = 0; m_pc = 32'h0; m_cnt = 0;
      m_inst = NOP_W; m_bpc = 0; m_valid = 0;
    end else if (m_boot || m_halt || br) begin
      if (!m_boot && !m_halt) m_pc = tgt & 32'hFFFF_FFFC;
      m_boot = 0;
      m_inst = NOP_W; m_bpc = 0; m_valid = 0;
    end else if (!stall) begin
      m_inst = mem(m_pc); m_bpc = m_pc; m_valid = 1;
      m_pc = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_inst == HALT_W) m_halt = 1;
    end
  end

  always @(negedge clk) if (started) begin
    chk("imem_addr", addr, m_pc);
    chk("pc_out_B", pc_b, m_bpc);
    chk("IM_out_B", im_b, m_inst);
    chk("valid_B", {31'd0, valid_b}, {31'd0, m_valid});
    chk("halted", {31'd0, hlt}, {31'd0, m_halt});
    chk("fetch_count", cnt, m_cnt);
  end

  initial begin
    rst = 1; stall = 0; br = 0; tgt = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, valid_b}, 32'd0);
    chk("rst_im", im_b, NOP_W);
    chk("rst_count", cnt, 32'd0);
    chk("rst_addr2", addr2, 32'hFFFF_FFFC);
    rst = 0;
    @(negedge clk);
    chk("boot_valid", {31'd0, valid_b}, 32'd0);
    chk("boot_addr", addr, 32'h0);
    @(negedge clk);
    chk("first_im", im_b, 32'h0050_0093);
    chk("first_model_im", m_inst, 32'h0050_0093);
    chk("first_pc", pc_b, 32'h0);
    chk("first_valid", {31'd0, valid_b}, 32'd1);
    chk("wrap_addr2", addr2, 32'h0);
    @(negedge clk);
    chk("second_im", im_b, 32'h00A0_0113);
    chk("second_addr", addr, 32'h8);
    stall = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_addr", addr, 32'h8);
      chk("stall_im", im_b, 32'h00A0_0113);
      chk("stall_count", cnt, 32'd2);
    end
    stall = 0;
    @(negedge clk);
    chk("resume_addr", addr, 32'hC);
    chk("resume_pc", pc_b, 32'h8);
    br = 1; stall = 1; tgt = 32'h43;
    @(negedge clk);
    chk("br_addr", addr, 32'h40);
    chk("br_valid", {31'd0, valid_b}, 32'd0);
    stall = 0; tgt = 32'h10;
    @(negedge clk);
    br = 0;
    @(negedge clk);
    chk("halt_im", im_b, HALT_W);
    chk("halt_valid", {31'd0, valid_b}, 32'd1);
    chk("halt_flag", {31'd0, hlt}, 32'd1);
    chk("halt_addr", addr, 32'h14);
    @(negedge clk);
    chk("halt_bubble", {31'd0, valid_b}, 32'd0);
    br = 1; tgt = 32'h200;
    @(negedge clk);
    chk("halt_br_ignored", addr, 32'h14);
    chk("halt_count", cnt, 32'd4);
    br = 0; rst = 1;
    @(negedge clk);
    chk("halt_rst_flag", {31'd0, hlt}, 32'd0);
    chk("halt_rst_count", cnt, 32'd0);
    rst = 0;
    @(negedge clk);
    br = 1; tgt = 32'h10;
    @(negedge clk);
    tgt = 32'h100;
    @(negedge clk);
    chk("flush_halt", {31'd0, hlt}, 32'd0);
    chk("flush_addr", addr, 32'h100);
    br = 0;
    @(negedge clk);
    chk("flush_valid", {31'd0, valid_b}, 32'd1);
    chk("flush_pc", pc_b, 32'h100);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 49) == 0;
      stall = $urandom_range(0, 3) == 0;
      br = $urandom_range(0, 5) == 0;
      case ($urandom_range(0, 9))
        0: tgt = 32'h10 | $urandom_range(0, 3);
        1: tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: tgt = $urandom;
      endcase
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
